// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the framed serial-to-parallel receiver.
// Optional feature macro: SIPO_FRAME_RX_PARITY_EN (adds the PARITY state).
package sipo_rx_pkg;

`ifdef SIPO_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_STOP   = 2'd3
    } rx_state_e;
`endif

    // Line levels that delimit a frame.
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Bus bundle between the receiver and its upstream serial source / consumer.
// Optional feature macro: SIPO_FRAME_RX_PARITY_EN (parity_err is live only then).
interface sipo_frame_rx_if #(
    parameter int DATA_W = 8
) ();
    logic              serial_in;
    logic              bit_en;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;

    // Environment side: drives the line and the consumer handshake.
    modport master (
        output serial_in, bit_en, data_ready,
        input  data_out, data_valid, frame_err, parity_err, overrun
    );

    // Receiver side.
    modport slave (
        input  serial_in, bit_en, data_ready,
        output data_out, data_valid, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/sipo_rx_hold.sv
// Single-entry valid/ready holding register with overrun detection.
// A load while the entry is full and not being read drops the new word.
module sipo_rx_hold #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              overrun_o
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    // Next-state: a same-edge read frees the slot for the incoming word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (load_i) begin
            if (!valid_q || rd_i) begin
                data_d  = word_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rd_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry and overrun pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;
endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial-to-parallel receiver: start(1), DATA_W bits LSB first,
// optional even parity, stop(0). Completed good words go to a holding register.
// Optional feature macro: SIPO_FRAME_RX_PARITY_EN.
module sipo_frame_rx
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    sipo_frame_rx_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
    logic              done;
    logic              load;
`ifdef SIPO_FRAME_RX_PARITY_EN
    logic              par_q, par_d;
`endif

    // Frame FSM: advances only on bit_en strobes; errors resolved at the stop sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        done    = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (bus.bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.serial_in == START_BIT) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d[cnt_q] = bus.serial_in;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef SIPO_FRAME_RX_PARITY_EN
                ST_PARITY: begin
                    par_d   = bus.serial_in;
                    state_d = ST_STOP;
                end
`endif
                ST_STOP: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    ferr_d  = (bus.serial_in != STOP_BIT);
`ifdef SIPO_FRAME_RX_PARITY_EN
                    // Even parity: data bits XOR parity bit must be zero.
                    perr_d  = (^shreg_q) ^ par_q;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign load = done && !ferr_d && !perr_d;

    // FSM, shift register and error pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

`ifdef SIPO_FRAME_RX_PARITY_EN
    // Captured parity bit of the current frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    sipo_rx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (load),
        .word_i    (shreg_d),
        .rd_i      (bus.data_ready),
        .data_o    (bus.data_out),
        .valid_o   (bus.data_valid),
        .overrun_o (bus.overrun)
    );

    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx (parity variant via SIPO_FRAME_RX_PARITY_EN).
module tb_sipo_frame_rx;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sipo_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    sipo_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    // Observation of the consumer side, filled by step().
    logic [DATA_W-1:0] got[$];
    int n_ferr, n_perr, n_ovr;
    logic last_valid = 1'b0;
    logic [DATA_W-1:0] last_data = '0;

    task automatic step();
        @(posedge clk);
        #1;
        if (last_valid && bus.data_ready) got.push_back(last_data);
        if (bus.frame_err)  n_ferr++;
        if (bus.parity_err) n_perr++;
        if (bus.overrun)    n_ovr++;
        last_valid = bus.data_valid;
        last_data  = bus.data_out;
    endtask

    task automatic clear_mon();
        got.delete();
        n_ferr = 0;
        n_perr = 0;
        n_ovr  = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.bit_en = 1'b0;
        bus.serial_in = 1'b0;
        bus.data_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        last_valid = 1'b0;
        clear_mon();
    endtask

    // Drives one frame; gap = idle cycles (bit_en=0, random line) after each bit.
    task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop,
                              input logic par, input int gap, input logic rdy_stop);
        logic bits[$];
        bits.push_back(1'b1);
        for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
`ifdef SIPO_FRAME_RX_PARITY_EN
        bits.push_back(par);
`endif
        bits.push_back(stop);
        for (int i = 0; i < bits.size(); i++) begin
            bus.serial_in = bits[i];
            bus.bit_en = 1'b1;
            if (rdy_stop && i == bits.size() - 1) bus.data_ready = 1'b1;
            step();
            if (rdy_stop && i == bits.size() - 1) bus.data_ready = 1'b0;
            bus.bit_en = 1'b0;
            for (int g = 0; g < gap; g++) begin
                bus.serial_in = 1'($urandom_range(0, 1));
                step();
            end
        end
        bus.serial_in = 1'b0;
    endtask

    task automatic drain();
        bus.data_ready = 1'b1;
        step();
        bus.data_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.bit_en = 1'b1;
        bus.serial_in = 1'b1;
        bus.data_ready = 1'b0;
        step();
        step();
        total++;
        if (bus.data_valid !== 1'b0 || bus.data_out !== '0) begin
            bad++;
            $display("FAIL reset_data: valid=%b data=%h required valid=0 data=00", bus.data_valid, bus.data_out);
        end
        total++;
        if ({bus.frame_err, bus.parity_err, bus.overrun} !== 3'b000) begin
            bad++;
            $display("FAIL reset_pulses: got %b%b%b required 000", bus.frame_err, bus.parity_err, bus.overrun);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        clear_mon();
        send_frame(8'hA5, 1'b0, ^8'hA5, 0, 1'b0);
        total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hA5) begin
            bad++;
            $display("FAIL basic_latency: valid=%b data=%h required valid=1 data=a5", bus.data_valid, bus.data_out);
        end
        drain();
        total++;
        if (got.size() != 1 || got[0] !== 8'hA5 || bus.data_valid !== 1'b0 || n_ferr != 0) begin
            bad++;
            $display("FAIL basic_read: count=%0d valid=%b ferr=%0d required count=1 word=a5 valid=0 ferr=0",
                     got.size(), bus.data_valid, n_ferr);
        end
    endtask

    task automatic test_overrun();
        clear_mon();
        send_frame(8'h3C, 1'b0, ^8'h3C, 0, 1'b0);
        send_frame(8'h5A, 1'b0, ^8'h5A, 0, 1'b0);
        step();
        total++;
        if (n_ovr != 1 || bus.data_out !== 8'h3C || bus.data_valid !== 1'b1) begin
            bad++;
            $display("FAIL overrun: pulses=%0d data=%h valid=%b required pulses=1 data=3c valid=1",
                     n_ovr, bus.data_out, bus.data_valid);
        end
        drain();
        total++;
        if (got.size() != 1 || got[0] !== 8'h3C) begin
            bad++;
            $display("FAIL overrun_drain: count=%0d required 1 word 3c", got.size());
        end
    endtask

    task automatic test_same_edge();
        clear_mon();
        send_frame(8'h11, 1'b0, ^8'h11, 0, 1'b0);
        send_frame(8'h22, 1'b0, ^8'h22, 0, 1'b1);
        total++;
        if (got.size() != 1 || got[0] !== 8'h11 || bus.data_valid !== 1'b1 ||
            bus.data_out !== 8'h22 || n_ovr != 0) begin
            bad++;
            $display("FAIL same_edge: count=%0d valid=%b data=%h ovr=%0d required count=1 valid=1 data=22 ovr=0",
                     got.size(), bus.data_valid, bus.data_out, n_ovr);
        end
        drain();
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'hFF, 1'b1, ^8'hFF, 0, 1'b0);
        step();
        step();
        total++;
        if (n_ferr != 1 || bus.data_valid !== 1'b0 || n_ovr != 0) begin
            bad++;
            $display("FAIL frame_err: pulses=%0d valid=%b ovr=%0d required pulses=1 valid=0 ovr=0",
                     n_ferr, bus.data_valid, n_ovr);
        end
    endtask

`ifdef SIPO_FRAME_RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        send_frame(8'h01, 1'b0, 1'b0, 0, 1'b0);
        step();
        total++;
        if (n_perr != 1 || bus.data_valid !== 1'b0) begin
            bad++;
            $display("FAIL parity_bad: pulses=%0d valid=%b required pulses=1 valid=0", n_perr, bus.data_valid);
        end
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0);
        total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h01 || n_perr != 1) begin
            bad++;
            $display("FAIL parity_good: valid=%b data=%h perr=%0d required valid=1 data=01 perr=1",
                     bus.data_valid, bus.data_out, n_perr);
        end
        drain();
        clear_mon();
        send_frame(8'h01, 1'b1, 1'b0, 0, 1'b0);
        step();
        total++;
        if (n_perr != 1 || n_ferr != 1 || bus.data_valid !== 1'b0) begin
            bad++;
            $display("FAIL parity_and_frame: perr=%0d ferr=%0d valid=%b required 1 1 0", n_perr, n_ferr, bus.data_valid);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [DATA_W-1:0] c3;
        c3 = 8'hC3;
        clear_mon();
        send_frame(8'h77, 1'b0, ^8'h77, 0, 1'b0);
        bus.bit_en = 1'b1;
        bus.serial_in = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.serial_in = c3[i];
            step();
        end
        bus.bit_en = 1'b0;
        rst_n = 1'b0;
        step();
        total++;
        if (bus.data_valid !== 1'b0 || bus.data_out !== '0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b data=%h required valid=0 data=00", bus.data_valid, bus.data_out);
        end
        rst_n = 1'b1;
        last_valid = 1'b0;
        clear_mon();
        step();
        send_frame(8'hC3, 1'b0, ^8'hC3, 0, 1'b0);
        drain();
        total++;
        if (got.size() != 1 || got[0] !== 8'hC3 || n_ferr != 0 || n_perr != 0 || n_ovr != 0) begin
            bad++;
            $display("FAIL reset_resume: count=%0d ferr=%0d perr=%0d ovr=%0d required one word c3, no errors",
                     got.size(), n_ferr, n_perr, n_ovr);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        bus.data_ready = 1'b1;
        send_frame(8'h12, 1'b0, ^8'h12, 2, 1'b0);
        send_frame(8'h34, 1'b0, ^8'h34, 2, 1'b0);
        step();
        step();
        bus.data_ready = 1'b0;
        total++;
        if (got.size() != 2 || n_ferr != 0 || n_perr != 0 || n_ovr != 0) begin
            bad++;
            $display("FAIL b2b_count: count=%0d ferr=%0d perr=%0d ovr=%0d required 2 0 0 0",
                     got.size(), n_ferr, n_perr, n_ovr);
        end else begin
            total++;
            if (got[0] !== 8'h12 || got[1] !== 8'h34) begin
                bad++;
                $display("FAIL b2b_order: got %h %h required 12 34", got[0], got[1]);
            end
        end
    endtask

    // Random frames with random strobe spacing; model keeps only good words.
    task automatic test_random();
        logic [DATA_W-1:0] exp_q[$];
        int exp_ferr, exp_perr;
        logic [DATA_W-1:0] w;
        logic stop_bad, par_bad;
        exp_ferr = 0;
        exp_perr = 0;
        clear_mon();
        bus.data_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            w = DATA_W'($urandom);
            stop_bad = ($urandom_range(0, 4) == 0);
`ifdef SIPO_FRAME_RX_PARITY_EN
            par_bad = ($urandom_range(0, 4) == 0);
`else
            par_bad = 1'b0;
`endif
            if (stop_bad) exp_ferr++;
            if (par_bad) exp_perr++;
            if (!stop_bad && !par_bad) exp_q.push_back(w);
            send_frame(w, stop_bad, (^w) ^ par_bad, int'($urandom_range(0, 3)), 1'b0);
        end
        step();
        step();
        bus.data_ready = 1'b0;
        total++;
        if (got.size() != exp_q.size() || n_ferr != exp_ferr || n_perr != exp_perr || n_ovr != 0) begin
            bad++;
            $display("FAIL random_counts: words=%0d/%0d ferr=%0d/%0d perr=%0d/%0d ovr=%0d/0",
                     got.size(), exp_q.size(), n_ferr, exp_ferr, n_perr, exp_perr, n_ovr);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL random_word[%0d]: got %h required %h", i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_same_edge();
        test_frame_err();
`ifdef SIPO_FRAME_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sipo_frame_rx.md
SIPO_FRAME_RX -- requirements
Module: sipo_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 serial_in  input  1  serial line, driven by the upstream SISO stage's serial_out; idle level 0.
REQ-005 bit_en  input  1  sample strobe; serial_in is sampled only on clk edges where bit_en=1.
REQ-006 data_out  output  DATA_W  received word; valid while data_valid=1.
REQ-007 data_valid  output  1  holding register contains an unread word.
REQ-008 data_ready  input  1  consumer accepts; transfer occurs on an edge with data_valid=1 and data_ready=1.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
REQ-010 parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 when parity is compiled out).
REQ-011 overrun  output  1  one-cycle pulse: completed frame dropped because the holding register was full.

Function
REQ-012 Frame format, in sampled bits: start bit (1), DATA_W data bits LSB first, optional parity bit, stop bit (0).
REQ-013 FSM states: IDLE, DATA, PARITY, STOP; state advances only on bit_en=1 edges.
REQ-014 IDLE: serial_in=1 sampled -> DATA with bit counter=0; serial_in=0 -> stay IDLE.
REQ-015 DATA: shift serial_in into the shift register at bit position = counter, increment counter; after bit DATA_W-1 -> PARITY if parity is enabled, otherwise -> STOP.
REQ-016 PARITY: sample the parity bit -> STOP.
REQ-017 STOP: sample stop bit -> IDLE; frame completion happens on this edge.
REQ-018 On completion with stop=0 and no parity error, load the word into the holding register when it is empty or being read on that same edge; otherwise drop the word and pulse overrun.
REQ-019 On completion with stop=1, drop the word, pulse frame_err, and leave the holding register unchanged.
REQ-020 On completion with a parity mismatch, drop the word, pulse parity_err, and leave the holding register unchanged; if stop=1 also holds, frame_err and parity_err both pulse.
REQ-021 Latency: data_valid rises on the clk edge that samples the stop bit, so it is visible in the following cycle.
REQ-022 A read and a load on the same edge: the new word replaces the old word, data_valid stays 1, and no overrun is raised.
REQ-023 data_out and data_valid hold stable while data_valid=1 and data_ready=0.
REQ-024 Error and overrun pulses last exactly one clk cycle regardless of bit_en.
REQ-025 Back-to-back frames: a start bit may be sampled on the bit_en edge immediately after STOP.

Reset
REQ-026 While reset=0: state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0.
REQ-027 Reset asserted mid-frame discards the partial frame and any held word; reception resumes from IDLE after release.

Configuration
REQ-028 Macro SIPO_FRAME_RX_PARITY_EN: when defined, the PARITY state exists and the frame carries an even-parity bit (XOR of the data bits and the parity bit must equal 0).
REQ-029 When SIPO_FRAME_RX_PARITY_EN is undefined, the PARITY state is absent, the frame is DATA_W+2 bits, and parity_err is tied to 0.

Structure
REQ-030 A shared package sipo_rx_pkg holds the FSM state enum typedef and the START_BIT=1 and STOP_BIT=0 constants.
REQ-031 One sub-module, sipo_rx_hold, implements the single-entry valid/ready holding register together with overrun detection.

Verification
REQ-032 bit_en=1, parity off, stream 1,10100101(LSB first),0 -> data_out=8'hA5 and data_valid=1 one cycle after the stop sample.
REQ-033 Word 8'h3C held with data_ready=0 while frame 8'h5A completes -> overrun pulses once, data_out remains 8'h3C.
REQ-034 Frame 8'hFF with stop bit 1 -> frame_err pulses once, data_valid stays 0.
REQ-035 PARITY_EN defined, word 8'h01 with parity bit 0 -> parity_err pulses; same word with parity bit 1 -> data_out=8'h01.
REQ-036 reset driven to 0 after 4 data bits, then released, then full frame 8'hC3 -> only 8'hC3 delivered.
REQ-037 bit_en=1 every 3rd cycle, two back-to-back frames 8'h12 and 8'h34 with data_ready=1 -> both delivered in order, no errors.
